dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder (slave end) of the CPU load/store interface. The MEM stage raises a request
//  and holds it; this block serves it after a fixed number of wait states. It stalls the pipeline through
//  the CTRL stall-request input until the request completes. Replaces the single-cycle DATAMEM for
//  multi-cycle memory timing.
// PARAMETERS
//  ADDR_WIDTH   10  word-address bits; the array holds 2**ADDR_WIDTH 32-bit words
//  WAIT_CYCLES  2   wait states between request acceptance and ack (0..15)
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-high reset
//  req_i       in   1   access request from MEM stage; held high until ack_o
//  we_i        in   1   1 = store, 0 = load
//  addr_i      in   32  byte address
//  wdata_i     in   32  store data, already lane-aligned
//  sel_i       in   4   byte enables; sel_i[3] = bits 31:24
//  rdata_o     out  32  load data, full word; valid while ack_o=1
//  ack_o       out  1   one-cycle completion pulse
//  addr_err_o  out  1   misaligned access flag; valid while ack_o=1
//  stallreq_o  out  1   stall request to CTRL
// BEHAVIOUR
//  Reset (async): state=IDLE; ack_o=0, addr_err_o=0, rdata_o=0; wait counter=0; latched request cleared.
//   Memory contents are not cleared.
//  FSM states: IDLE, WAIT, DONE.
//   IDLE: req_i=1 at a clock edge latches we/addr/wdata/sel.
//    Next state is WAIT with counter=WAIT_CYCLES-1, or DONE directly if WAIT_CYCLES=0.
//   WAIT: counter decrements each cycle. Leaving at counter=0 (next state DONE) performs the access:
//    - store: writes the enabled bytes to mem[addr[ADDR_WIDTH+1:2]].
//    - load: registers the word into rdata_o.
//   DONE: ack_o=1 for exactly this cycle; next state is IDLE unconditionally.
//    The req_i seen in DONE belongs to the completing access and is not re-accepted.
//  Latency: req_i first high in cycle T (state IDLE) -> ack_o high in cycle T+WAIT_CYCLES+1.
//   Back-to-back requests: the next request is accepted no earlier than the cycle after DONE.
//  stallreq_o = req_i & ~ack_o (combinational). The pipeline is frozen until the ack cycle and advances
//   at the end of it.
//  Misalignment: addr_err_o=1 in DONE if either
//   - sel_i=4'b1111 and addr[1:0]!=0, or
//   - sel_i is 4'b0011 or 4'b1100 and addr[0]!=0.
//   On error: no write, rdata_o=0, ack still issued.
//  Address wrap: bits above ADDR_WIDTH+1 are ignored (aliasing). addr[1:0] selects no extra lanes;
//   sel_i is authoritative.
//  Store with sel_i=0: acked, memory unchanged.
//  Load: rdata_o returns the full word regardless of sel_i; byte/half extraction happens in the MEM stage.
//  rdata_o holds its value until the next load completes. addr_err_o is 0 outside DONE.
//  req_i dropping before ack (flush): the access in flight still completes internally, but ack_o is
//   forced to 0 and a pending store is discarded if req_i=0 in the final WAIT cycle.
//  Reset asserted mid-access: access aborted immediately, no write occurs, state=IDLE.
//  Read-during-write to the same word: a load accepted after a store's DONE returns the new data.
// TESTING
//  1. WAIT_CYCLES=2: store 0xDEADBEEF, addr 0x10, sel 1111 -> ack in cycle T+3; stallreq_o high T..T+2,
//     low at T+3; subsequent load of 0x10 returns 0xDEADBEEF.
//  2. Byte store 0x000000AA, sel 0001, addr 0x10 over 0xDEADBEEF -> load returns 0xDEADBEAA;
//     then sel 0000 store -> word unchanged.
//  3. Load, addr 0x12, sel 1111 -> ack with addr_err_o=1, rdata_o=0; a store to addr 0x13 with
//     sel 1100 -> addr_err_o=1, memory unchanged.
//  4. Back-to-back: req held through DONE then kept high for a new access -> exactly one ack per access,
//     second ack at DONE+WAIT_CYCLES+2; WAIT_CYCLES=0 gives ack at T+1.
//  5. Reset pulsed in the WAIT state of a store to 0x20 (old value 0x12345678) -> outputs zero at once;
//     a later load of 0x20 returns 0x12345678.
//  6. ADDR_WIDTH=10: store to 0x1000 aliases to 0x0000 -> load of 0x0000 returns the stored value.

Source files
------------

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Slave end of the CPU data-memory load/store interface. The MEM stage raises
//   req_i and holds it; the request is latched, served after WAIT_CYCLES wait
//   states and completed with a one-cycle ack_o. Until then stallreq_o freezes
//   the pipeline. Misaligned word/half accesses are flagged and suppressed.
//
// Parameters
//   ADDR_WIDTH   word-address bits (array holds 2**ADDR_WIDTH 32-bit words)
//   WAIT_CYCLES  wait states between acceptance and ack (0..15)
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous, active-high reset
//   req_i        access request, held high until ack_o
//   we_i         1 = store, 0 = load
//   addr_i       byte address (bits above ADDR_WIDTH+1 alias)
//   wdata_i      lane-aligned store data
//   sel_i        byte enables, sel_i[3] = bits 31:24
//   rdata_o      full load word, valid while ack_o=1, held until next load
//   ack_o        one-cycle completion pulse
//   addr_err_o   misaligned-access flag, valid while ack_o=1
//   stallreq_o   stall request to the pipeline controller
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  sel_i,
   output logic [31:0] rdata_o,
   output logic        ack_o,
   output logic        addr_err_o,
   output logic        stallreq_o
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_t                state, next_state;
   logic [3:0]            cnt;
   logic                  latch_en, access_en;

   logic                  lat_we;
   logic [ADDR_WIDTH+1:0] lat_addr;
   logic [31:0]           lat_wdata;
   logic [3:0]            lat_sel;

   logic                  op_we;
   logic [ADDR_WIDTH+1:0] op_addr;
   logic [31:0]           op_wdata;
   logic [3:0]            op_sel;
   logic                  op_err;
   logic [ADDR_WIDTH-1:0] op_idx;
   logic                  write_en;

   logic [31:0]           mem [0:2**ADDR_WIDTH-1];

   // Address bits above the array alias and are deliberately ignored.
   logic                  unused_addr_hi;
   assign unused_addr_hi = ^addr_i[31:ADDR_WIDTH+2];

   // ---------------------------------------------------------------- FSM
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values of the others; blocking here would create order races.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // NOTE: every signal written here gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      next_state = state;
      latch_en   = 1'b0;
      access_en  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (req_i) begin
               latch_en = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  next_state = S_DONE;
                  access_en  = 1'b1;
               end else begin
                  next_state = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt == 4'd0) begin
               next_state = S_DONE;
               access_en  = 1'b1;
            end
         end
         // The req_i still high here belongs to the completing access.
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // ------------------------------------------------ counter and request latch
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= 4'd0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_sel   <= 4'd0;
      end else if (latch_en) begin
         cnt       <= WAIT_INIT;
         lat_we    <= we_i;
         lat_addr  <= addr_i[ADDR_WIDTH+1:0];
         lat_wdata <= wdata_i;
         lat_sel   <= sel_i;
      end else if (state == S_WAIT && cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end

   // With zero wait states the access happens on the accepting edge, before
   // the latch holds anything, so the live inputs are used in IDLE.
   always_comb begin
      if (state == S_IDLE) begin
         op_we    = we_i;
         op_addr  = addr_i[ADDR_WIDTH+1:0];
         op_wdata = wdata_i;
         op_sel   = sel_i;
      end else begin
         op_we    = lat_we;
         op_addr  = lat_addr;
         op_wdata = lat_wdata;
         op_sel   = lat_sel;
      end
   end

   assign op_idx = op_addr[ADDR_WIDTH+1:2];
   assign op_err = ((op_sel == 4'b1111) && (op_addr[1:0] != 2'b00)) ||
                   (((op_sel == 4'b0011) || (op_sel == 4'b1100)) && op_addr[0]);

   // A store is dropped if the requester has flushed (req_i low) on the access
   // edge, if misaligned, or if reset is asserted on that edge.
   assign write_en = access_en & op_we & ~op_err & req_i & ~reset;

   // ---------------------------------------------------------------- storage
   // NOTE: the array has no reset; contents survive reset and it maps to RAM.
   always_ff @(posedge clk) begin
      if (write_en) begin
         for (int b = 0; b < 4; b++) begin
            if (op_sel[b]) mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
         end
      end
   end

   // --------------------------------------------------------------- outputs
   // Registered on the edge entering DONE, so they are high only in DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack_o      <= 1'b0;
         addr_err_o <= 1'b0;
         rdata_o    <= '0;
      end else begin
         ack_o      <= access_en & req_i;
         addr_err_o <= access_en & op_err;
         if (access_en && !op_we) rdata_o <= op_err ? 32'd0 : mem[op_idx];
      end
   end

   assign stallreq_o = req_i & ~ack_o;

endmodule
